// File: rtl/overlay_frame_ctrl.sv
// Frame-synchronous overlay sequencer: filters per-frame colour results into a locked colour and
// shadows ROI geometry so it only changes at frame boundaries. Optional blink: OVERLAY_BLINK_EN.
module overlay_frame_ctrl #(
    parameter logic [9:0] ROI_X_START_RST = 10'd100,
    parameter logic [9:0] ROI_X_END_RST   = 10'd220,
    parameter logic [9:0] ROI_Y_START_RST = 10'd60,
    parameter logic [9:0] ROI_Y_END_RST   = 10'd180,
    parameter logic [1:0] BOX_THICKNESS   = 2'd2,
    parameter logic [3:0] STABLE_FRAMES   = 4'd4,
    parameter logic [3:0] CLEAR_FRAMES    = 4'd8,
    parameter logic [3:0] BLINK_FRAMES    = 4'd8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       raw_valid,
    input  logic [1:0] raw_color,
    input  logic       raw_white,
    input  logic       cfg_we,
    input  logic [9:0] cfg_x_start,
    input  logic [9:0] cfg_x_end,
    input  logic [9:0] cfg_y_start,
    input  logic [9:0] cfg_y_end,
    output logic [9:0] roi_x_start,
    output logic [9:0] roi_x_end,
    output logic [9:0] roi_y_start,
    output logic [9:0] roi_y_end,
    output logic [1:0] color_out,
    output logic       white_out,
    output logic       indicator_on,
    output logic       turn_done,
    output logic       cfg_pending,
    output logic       cfg_err,
    output logic [1:0] state_out
);

    typedef enum logic [1:0] {
        S_SEARCH  = 2'b00,
        S_CONFIRM = 2'b01,
        S_LOCKED  = 2'b10,
        S_CLEAR   = 2'b11
    } state_t;

    // Each colour is its own candidate so a colour change restarts the stability count.
    typedef enum logic [2:0] {
        C_NONE  = 3'd0,
        C_RED   = 3'd1,
        C_GREEN = 3'd2,
        C_BLUE  = 3'd3,
        C_WHITE = 3'd4
    } cand_t;

    localparam logic [10:0] MARGIN = {8'd0, BOX_THICKNESS, 1'b0};
    localparam logic [10:0] X_MAX  = 11'd320;
    localparam logic [10:0] Y_MAX  = 11'd240;

    state_t     state_q, state_d;
    cand_t      cand_prev_q, cand;
    logic [3:0] cnt_q, cnt_d;
    logic [1:0] color_q, color_d;
    logic       white_q, white_d;
    logic       turn_done_q, turn_done_d;
    logic       valid_tick;
    logic       is_color;

    logic [9:0] roi_xs_q, roi_xe_q, roi_ys_q, roi_ye_q;
    logic [9:0] pend_xs_q, pend_xe_q, pend_ys_q, pend_ye_q;
    logic       pending_q;
    logic       cfg_err_q;
    logic       cfg_ok;
    logic       cfg_accept;

    assign valid_tick = frame_tick & raw_valid;
    assign is_color   = !raw_white && (raw_color != 2'b00);

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        cand        = C_NONE;
        cnt_d       = cnt_q;
        state_d     = state_q;
        if (raw_white) begin
            cand = C_WHITE;
        end else if (raw_color != 2'b00) begin
            cand = cand_t'({1'b0, raw_color});
        end

        if (cand == cand_prev_q) begin
            cnt_d = (cnt_q == 4'hf) ? 4'hf : cnt_q + 4'd1;
        end else begin
            cnt_d = 4'd1;
        end

        if (valid_tick) begin
            case (state_q)
                S_SEARCH: begin
                    if (is_color) begin
                        state_d = (cnt_d >= STABLE_FRAMES) ? S_LOCKED : S_CONFIRM;
                    end
                end
                S_CONFIRM: begin
                    if (!is_color) begin
                        state_d = S_SEARCH;
                    end else if (cnt_d >= STABLE_FRAMES) begin
                        state_d = S_LOCKED;
                    end
                end
                S_LOCKED: begin
                    if (cand == C_WHITE && cnt_d >= CLEAR_FRAMES) begin
                        state_d = S_CLEAR;
                    end
                end
                default: begin
                    if (cand != C_WHITE) begin
                        state_d = S_SEARCH;
                    end
                end
            endcase
        end

        // Colour is captured only on the LOCKED entry tick and then held.
        color_d = 2'b00;
        if (state_d == S_LOCKED) begin
            color_d = (state_q == S_LOCKED) ? color_q : raw_color;
        end
        white_d     = (state_d == S_CLEAR);
        turn_done_d = (state_d == S_CLEAR) && (state_q != S_CLEAR);
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_SEARCH;
            cand_prev_q <= C_NONE;
            cnt_q       <= 4'd0;
            color_q     <= 2'b00;
            white_q     <= 1'b0;
            turn_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            color_q     <= color_d;
            white_q     <= white_d;
            turn_done_q <= turn_done_d;
            if (valid_tick) begin
                cand_prev_q <= cand;
                cnt_q       <= cnt_d;
            end
        end
    end

    // Sums at 11 bits cannot wrap, so a huge start never passes as a small one.
    always_comb begin
        cfg_ok = (({1'b0, cfg_x_start} + MARGIN) <= {1'b0, cfg_x_end})
              && ({1'b0, cfg_x_end} <= X_MAX)
              && (({1'b0, cfg_y_start} + MARGIN) <= {1'b0, cfg_y_end})
              && ({1'b0, cfg_y_end} <= Y_MAX);
    end

    assign cfg_accept = cfg_we & cfg_ok;

    always_ff @(posedge clk) begin
        if (reset) begin
            roi_xs_q  <= ROI_X_START_RST;
            roi_xe_q  <= ROI_X_END_RST;
            roi_ys_q  <= ROI_Y_START_RST;
            roi_ye_q  <= ROI_Y_END_RST;
            pending_q <= 1'b0;
            cfg_err_q <= 1'b0;
        end else begin
            // The old pending value is applied even if a new write lands in the same cycle.
            if (frame_tick && pending_q) begin
                roi_xs_q <= pend_xs_q;
                roi_xe_q <= pend_xe_q;
                roi_ys_q <= pend_ys_q;
                roi_ye_q <= pend_ye_q;
            end
            if (cfg_accept) begin
                pending_q <= 1'b1;
            end else if (frame_tick) begin
                pending_q <= 1'b0;
            end
            cfg_err_q <= cfg_we & ~cfg_ok;
        end
    end

    // NOTE: the pending data registers carry no reset; they are only ever read while pending_q is set.
    always_ff @(posedge clk) begin
        if (cfg_accept) begin
            pend_xs_q <= cfg_x_start;
            pend_xe_q <= cfg_x_end;
            pend_ys_q <= cfg_y_start;
            pend_ye_q <= cfg_y_end;
        end
    end

`ifdef OVERLAY_BLINK_EN
    localparam logic [3:0] BLINK_LAST = BLINK_FRAMES - 4'd1;

    logic [3:0] blink_cnt_q;
    logic       ind_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            blink_cnt_q <= 4'd0;
            ind_q       <= 1'b1;
        end else if (state_d != S_CONFIRM) begin
            blink_cnt_q <= 4'd0;
            ind_q       <= 1'b1;
        end else if (state_q != S_CONFIRM) begin
            blink_cnt_q <= 4'd0;
            ind_q       <= 1'b1;
        end else if (frame_tick) begin
            if (blink_cnt_q >= BLINK_LAST) begin
                blink_cnt_q <= 4'd0;
                ind_q       <= ~ind_q;
            end else begin
                blink_cnt_q <= blink_cnt_q + 4'd1;
            end
        end
    end

    assign indicator_on = ind_q;
`else
    assign indicator_on = 1'b1;
`endif

    assign roi_x_start = roi_xs_q;
    assign roi_x_end   = roi_xe_q;
    assign roi_y_start = roi_ys_q;
    assign roi_y_end   = roi_ye_q;
    assign color_out   = color_q;
    assign white_out   = white_q;
    assign turn_done   = turn_done_q;
    assign cfg_pending = pending_q;
    assign cfg_err     = cfg_err_q;
    assign state_out   = state_q;

endmodule
